// File: rtl/zapper_pkg.sv
// Shared types and default constants for the light-gun shot sequencer.
// The optional hit-toggle LED output is enabled with the ZAPPER_DEBUG_EN macro.
package zapper_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    BLANK    = 3'd2,
    TARGET   = 3'd3,
    RESULT   = 3'd4,
    COOLDOWN = 3'd5
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_SHOTS_PER_DUCK  = 3;
  localparam int unsigned DEF_HIT_THRESHOLD   = 64;
  localparam int unsigned DEF_CNT_W           = 18;
  localparam int unsigned SHOTS_W             = 2;

  // Sense counter width: one bit of headroom above the threshold.
  function automatic int unsigned sense_width(input int unsigned threshold);
    return int'($clog2(threshold + 1)) + 1;
  endfunction

endpackage

// File: rtl/zapper_seq_if.sv
// Signal bundle between the shot sequencer and its neighbours
// (trigger pin, VGA timing, photodiode, pattern_gen).
interface zapper_seq_if;
  import zapper_pkg::*;

  logic               trigger;
  logic               frame_start;
  logic               in_target;
  logic               sensor;
  logic               reload;
  logic               force_black;
  logic               force_target;
  logic               hit;
  logic               miss;
  logic [SHOTS_W-1:0] shots_left;
  logic               busy;
  logic               debug;

  // Environment side: drives the raw inputs, observes the sequencer.
  modport master (
    output trigger, frame_start, in_target, sensor, reload,
    input  force_black, force_target, hit, miss, shots_left, busy, debug
  );

  // Sequencer side.
  modport slave (
    input  trigger, frame_start, in_target, sensor, reload,
    output force_black, force_target, hit, miss, shots_left, busy, debug
  );

endinterface

// File: rtl/zapper_seq_trigger_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debouncer and a
// one-cycle fire pulse on the rising edge of the debounced level.
module trigger_debounce
  import zapper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fire
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             fire_q,  fire_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fire_q  <= fire_d;
    end
  end

  // Any cycle agreeing with the current level restarts the stability count.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    fire_d = level_d & ~level_q;
  end

  assign level = level_q;
  assign fire  = fire_q;

endmodule

// File: rtl/zapper_seq.sv
// Light-gun shot sequencer: black frame, target frame, photodiode sampling,
// hit/miss pulse and shot bookkeeping. ZAPPER_DEBUG_EN adds a hit-toggle LED.
module zapper_seq
  import zapper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
  parameter int unsigned HIT_THRESHOLD   = DEF_HIT_THRESHOLD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  zapper_seq_if.slave  bus
);

  localparam int unsigned SENSE_W = sense_width(HIT_THRESHOLD);

  state_e               state_q, state_d;
  logic                 sens1_q, sens1_d;
  logic                 sens2_q, sens2_d;
  logic [SENSE_W-1:0]   sense_q, sense_d;
  logic [SHOTS_W-1:0]   shots_q, shots_d;
  logic                 force_black_q, force_black_d;
  logic                 force_target_q, force_target_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 busy_q, busy_d;

  logic                 trig_level;
  logic                 trig_fire;
  logic                 take_shot;
  logic                 enough_light;

  trigger_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .din   (bus.trigger),
    .level (trig_level),
    .fire  (trig_fire)
  );

  assign take_shot    = (state_q == IDLE) && trig_fire && (shots_q != '0);
  assign enough_light = (sense_q >= SENSE_W'(HIT_THRESHOLD));

  // State and output registers; async reset drops both force outputs at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sens1_q        <= 1'b0;
      sens2_q        <= 1'b0;
      sense_q        <= '0;
      shots_q        <= SHOTS_W'(SHOTS_PER_DUCK);
      force_black_q  <= 1'b0;
      force_target_q <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sens1_q        <= sens1_d;
      sens2_q        <= sens2_d;
      sense_q        <= sense_d;
      shots_q        <= shots_d;
      force_black_q  <= force_black_d;
      force_target_q <= force_target_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (take_shot)        state_d = ARM;
      ARM:      if (bus.frame_start)  state_d = BLANK;
      BLANK:    if (bus.frame_start)  state_d = TARGET;
      TARGET:   if (bus.frame_start)  state_d = RESULT;
      RESULT:                         state_d = COOLDOWN;
      COOLDOWN: if (!trig_level)      state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Outputs and datapath; force flags follow state_d so they are valid from pixel 0.
  always_comb begin
    sens1_d        = bus.sensor;
    sens2_d        = sens1_q;
    sense_d        = sense_q;
    shots_d        = shots_q;
    force_black_d  = (state_d == BLANK);
    force_target_d = (state_d == TARGET);
    hit_d          = 1'b0;
    miss_d         = 1'b0;
    busy_d         = (state_d != IDLE);

    if (state_q == TARGET && bus.in_target && sens2_q && (sense_q != '1)) begin
      sense_d = sense_q + SENSE_W'(1);
    end
    if (state_q == RESULT) begin
      hit_d   = enough_light;
      miss_d  = ~enough_light;
      sense_d = '0;
    end

    // A new duck overrides a same-cycle decrement.
    if (take_shot) begin
      shots_d = shots_q - SHOTS_W'(1);
    end
    if (bus.reload) begin
      shots_d = SHOTS_W'(SHOTS_PER_DUCK);
    end
  end

  assign bus.force_black  = force_black_q;
  assign bus.force_target = force_target_q;
  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.shots_left   = shots_q;
  assign bus.busy         = busy_q;

`ifdef ZAPPER_DEBUG_EN
  logic debug_q, debug_d;

  // LED toggles in step with each hit pulse.
  always_comb begin
    debug_d = debug_q ^ hit_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_q <= 1'b0;
    end else begin
      debug_q <= debug_d;
    end
  end

  assign bus.debug = debug_q;
`else
  assign bus.debug = 1'b0;
`endif

endmodule

// File: tb/tb_zapper_seq.sv
// Directed bench for zapper_seq with short frames and an 8-cycle debounce.
module tb_zapper_seq;

  localparam int FRAME = 400;
  localparam int DEB   = 8;

  logic clk;
  logic reset;

  zapper_seq_if zif ();

  zapper_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .SHOTS_PER_DUCK  (3),
    .HIT_THRESHOLD   (64),
    .CNT_W           (18)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (zif)
  );

  int total = 0;
  int bad   = 0;

  int model_shots;
  int dbg_par;

  int fb_cnt, ft_cnt, hit_cnt, miss_cnt, hit_at, miss_at, both_hm, both_f;
  int fire_cnt, fire_at, busy_at, busy_seen, force_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_debug();
`ifdef ZAPPER_DEBUG_EN
    return dbg_par;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame (or the first n cycles of one), with target and sensor windows.
  task automatic run_frame(input int n, input int ts, input int tl, input int ss, input int sl);
    fb_cnt = 0; ft_cnt = 0; hit_cnt = 0; miss_cnt = 0;
    hit_at = -1; miss_at = -1; both_hm = 0; both_f = 0;
    for (int c = 0; c < n; c++) begin
      zif.frame_start = (c == 0);
      zif.in_target   = (c >= ts) && (c < ts + tl);
      zif.sensor      = (c >= ss) && (c < ss + sl);
      step();
      fb_cnt   += int'(zif.force_black);
      ft_cnt   += int'(zif.force_target);
      hit_cnt  += int'(zif.hit);
      miss_cnt += int'(zif.miss);
      if (zif.hit && hit_at < 0) hit_at = c;
      if (zif.miss && miss_at < 0) miss_at = c;
      if (zif.hit && zif.miss) both_hm++;
      if (zif.force_black && zif.force_target) both_f++;
    end
    zif.frame_start = 1'b0;
    zif.in_target   = 1'b0;
    zif.sensor      = 1'b0;
  endtask

  // Trigger held for `hold` cycles then released for 12; optional reload on one cycle.
  task automatic pull(input int hold, input int reload_at);
    fire_cnt = 0; fire_at = -1; busy_at = -1; busy_seen = 0; force_seen = 0;
    zif.trigger = 1'b1;
    for (int i = 0; i < hold + 12; i++) begin
      if (i == hold) zif.trigger = 1'b0;
      zif.reload = (i == reload_at);
      step();
      if (u_dut.u_deb.fire) begin
        fire_cnt++;
        if (fire_at < 0) fire_at = i;
      end
      if (zif.busy && busy_at < 0) busy_at = i;
      busy_seen  |= int'(zif.busy);
      force_seen |= int'(zif.force_black | zif.force_target);
    end
    zif.reload = 1'b0;
  endtask

  task automatic shot(input string nm, input int tl, input int ss, input int sl,
                      input bit exp_hit, input int reload_at, input bit hold);
    pull(20, reload_at);
    check_eq({nm, "_fire_at"}, fire_at, DEB + 1);
    check_eq({nm, "_fire_cnt"}, fire_cnt, 1);
    check_eq({nm, "_busy_at"}, busy_at, DEB + 2);
    model_shots = (reload_at >= 0) ? 3 : model_shots - 1;
    check_eq({nm, "_shots_fire"}, int'(zif.shots_left), model_shots);
    if (hold) zif.trigger = 1'b1;
    run_frame(FRAME, 0, 0, 0, 0);
    check_eq({nm, "_blank_fb"}, fb_cnt, FRAME);
    check_eq({nm, "_blank_ft"}, ft_cnt, 0);
    run_frame(FRAME, 20, tl, ss, sl);
    check_eq({nm, "_tgt_ft"}, ft_cnt, FRAME);
    check_eq({nm, "_tgt_fb"}, fb_cnt, 0);
    run_frame(FRAME, 0, 0, 0, 0);
    check_eq({nm, "_hit_cnt"}, hit_cnt, exp_hit ? 1 : 0);
    check_eq({nm, "_miss_cnt"}, miss_cnt, exp_hit ? 0 : 1);
    check_eq({nm, "_pulse_at"}, exp_hit ? hit_at : miss_at, 1);
    check_eq({nm, "_force_after"}, fb_cnt + ft_cnt, 0);
    check_eq({nm, "_excl"}, both_hm + both_f, 0);
    if (exp_hit) dbg_par ^= 1;
    check_eq({nm, "_debug"}, int'(zif.debug), exp_debug());
    check_eq({nm, "_busy_end"}, int'(zif.busy), hold ? 1 : 0);
    check_eq({nm, "_shots_end"}, int'(zif.shots_left), model_shots);
  endtask

  initial begin
    reset = 1'b1;
    zif.trigger = 1'b0; zif.frame_start = 1'b0; zif.in_target = 1'b0;
    zif.sensor = 1'b0; zif.reload = 1'b0;
    model_shots = 3;
    dbg_par = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    check_eq("rst_shots", int'(zif.shots_left), 3);
    check_eq("rst_busy", int'(zif.busy), 0);
    check_eq("rst_force", int'(zif.force_black) + int'(zif.force_target), 0);
    check_eq("rst_hitmiss", int'(zif.hit) + int'(zif.miss), 0);
    check_eq("rst_debug", int'(zif.debug), 0);

    // Bounce: 3-cycle pulses never reach the debounce count.
    fire_cnt = 0; busy_seen = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) begin
        zif.trigger = (i < 3);
        step();
        fire_cnt  += int'(u_dut.u_deb.fire);
        busy_seen |= int'(zif.busy);
      end
    end
    zif.trigger = 1'b0;
    repeat (12) begin
      step();
      fire_cnt += int'(u_dut.u_deb.fire);
    end
    check_eq("bounce_fire", fire_cnt, 0);
    check_eq("bounce_busy", busy_seen, 0);

    shot("hit100", 100, 10, 200, 1'b1, -1, 1'b0);
    shot("miss10", 10, 10, 200, 1'b0, -1, 1'b0);
    shot("missout", 100, 130, 200, 1'b0, -1, 1'b0);

    // Out of ammo: pull is ignored.
    pull(20, -1);
    check_eq("empty_busy", busy_seen, 0);
    check_eq("empty_force", force_seen, 0);
    check_eq("empty_shots", int'(zif.shots_left), 0);

    zif.reload = 1'b1;
    step();
    zif.reload = 1'b0;
    step();
    model_shots = 3;
    check_eq("reload_shots", int'(zif.shots_left), 3);

    shot("thr64", 64, 10, 200, 1'b1, -1, 1'b0);
    shot("thr63", 63, 10, 200, 1'b0, -1, 1'b0);
    shot("rldfire", 100, 10, 200, 1'b1, DEB + 2, 1'b0);

    // Trigger re-pulled in BLANK and held: ignored, then stuck in COOLDOWN.
    shot("hold", 100, 10, 200, 1'b1, -1, 1'b1);
    repeat (30) step();
    check_eq("hold_cooldown_busy", int'(zif.busy), 1);
    zif.trigger = 1'b0;
    repeat (15) step();
    check_eq("hold_release_busy", int'(zif.busy), 0);
    check_eq("hold_shots", int'(zif.shots_left), model_shots);

    // Reset mid-TARGET.
    pull(20, -1);
    run_frame(FRAME, 0, 0, 0, 0);
    run_frame(50, 20, 100, 10, 200);
    check_eq("midrst_pre_ft", int'(zif.force_target), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_ft", int'(zif.force_target), 0);
    check_eq("midrst_fb", int'(zif.force_black), 0);
    check_eq("midrst_busy", int'(zif.busy), 0);
    check_eq("midrst_shots", int'(zif.shots_left), 3);
    check_eq("midrst_debug", int'(zif.debug), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dbg_par = 0;
    run_frame(FRAME, 20, 100, 10, 200);
    check_eq("postrst_hitmiss", hit_cnt + miss_cnt, 0);
    check_eq("postrst_force", fb_cnt + ft_cnt, 0);
    run_frame(FRAME, 0, 0, 0, 0);
    check_eq("postrst_hitmiss2", hit_cnt + miss_cnt, 0);
    check_eq("postrst_shots", int'(zif.shots_left), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zapper_seq.md
Name: zapper_seq

Overview:
- Light-gun shot sequencer sitting between the trigger pin, the VGA timing block and pattern_gen.
- On a debounced trigger pull it runs the zapper protocol:
  - waits for the next frame boundary;
  - forces one all-black frame, then one frame showing only the white target box;
  - samples the photodiode while the beam is inside the box.
- Emits a one-cycle hit or miss pulse, tracks remaining shots per duck and locks out re-fire until the trigger is released.

Parameters:
- DEBOUNCE_CYCLES, 250000, stable cycles needed to accept a trigger level change (10 ms at 25 MHz).
- SHOTS_PER_DUCK, 3, shots loaded on reload.
- HIT_THRESHOLD, 64, minimum count of in-box pixels with sensor high to declare a hit.
- CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  pixel clock, 25 MHz domain.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  raw trigger, already inverted to active-high, asynchronous to clk.
- frame_start  input  1  one-cycle pulse at the first cycle of each frame (row 0, col 0).
- in_target  input  1  high while the current pixel is valid and inside the target box.
- sensor  input  1  raw photodiode, active-high, asynchronous.
- reload  input  1  one-cycle pulse; refills shots to SHOTS_PER_DUCK (new duck).
- force_black  output  1  pattern_gen must draw all-black this frame.
- force_target  output  1  pattern_gen must draw black with a white target box this frame.
- hit  output  1  one-cycle pulse: shot registered a hit.
- miss  output  1  one-cycle pulse: shot missed.
- shots_left  output  2  remaining shots, 0..SHOTS_PER_DUCK.
- busy  output  1  high in any state other than IDLE.
- debug  output  1  see Optional Feature.

Behaviour:
- Synchronisers: trigger and sensor each pass through a 2-flop synchroniser; 2 cycles of latency before use.
- Debounce:
  - counter resets whenever synced trigger equals the debounced level;
  - debounced level flips after DEBOUNCE_CYCLES consecutive differing cycles;
  - a fire event is the rising edge of the debounced level.
- Reset values: all outputs 0 except shots_left = SHOTS_PER_DUCK; state = IDLE; debounced level = 0; sense counter = 0.
- State IDLE:
  - a fire event with shots_left > 0 decrements shots_left and goes to ARM;
  - a fire event with shots_left == 0 is ignored and the machine stays in IDLE.
- State ARM: wait for frame_start, then go to BLANK. force_black is asserted in the same cycle frame_start is seen, so it is registered high from the first pixel onward.
- State BLANK: force_black = 1 for exactly one frame. The next frame_start moves to TARGET: force_black = 0, force_target = 1.
- State TARGET:
  - each cycle with in_target && synced sensor increments the sense counter, saturating at all-ones;
  - the next frame_start moves to RESULT and drops force_target.
- State RESULT: one cycle. hit = 1 if sense counter >= HIT_THRESHOLD, else miss = 1. Clear the sense counter and go to COOLDOWN.
- State COOLDOWN: return to IDLE once the debounced trigger is 0.
- Output exclusivity: hit and miss are never high together; force_black and force_target are never high together.
- Reload:
  - honoured in any state and sets shots_left = SHOTS_PER_DUCK;
  - a shot in flight still completes;
  - if reload coincides with the IDLE fire decrement, reload wins (shots_left = SHOTS_PER_DUCK).
- Trigger while not IDLE: fire events are ignored; there is no queueing.
- Asynchronous reset mid-shot: immediately clears both force outputs, so the next frame is drawn normally.

Optional Feature:
- Macro ZAPPER_DEBUG_EN.
- When defined: debug is a toggle flip-flop that inverts on every hit pulse, giving a visible LED indication of hits.
- When undefined: debug is tied to 0 and the toggle flop is not built.

Decomposition:
- Package zapper_pkg holds:
  - the state enum typedef (IDLE, ARM, BLANK, TARGET, RESULT, COOLDOWN);
  - the default constants for the debounce count, shot count and threshold.
- One sub-module, trigger_debounce: synchroniser, debounce counter and rising-edge fire pulse, parameterised by DEBOUNCE_CYCLES. It is reusable for future buttons.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=8): trigger bounce pulses of 3 cycles produce no fire; a steady 20-cycle high produces exactly one fire, 2+8 cycles after the edge.
- Full shot, sensor high on 100 in_target cycles:
  - force_black high for exactly one frame, then force_target for exactly one frame;
  - hit pulses for 1 cycle after the second frame_start; shots_left goes 3 -> 2.
- Sensor high on only 10 in_target cycles → miss pulse, no hit. Sensor high outside in_target → miss.
- Three shots then a fourth pull: no busy, no force outputs, shots_left stays 0. Then reload → shots_left = 3.
- Trigger held high through RESULT: stays in COOLDOWN until release. A second pull during BLANK is ignored.
- Reset asserted mid-TARGET:
  - force_target drops asynchronously; no hit or miss pulses; shots_left = 3;
  - with ZAPPER_DEBUG_EN defined, debug toggles on each hit and returns to 0 on reset.
